// File: rtl/keypad_mux_display.sv
// keypad_mux_display: 4x4 keypad row scanner with debounce and key history,
// shown on a multiplexed, active-low seven-segment display.
module keypad_mux_display #(
    parameter int NDIGITS     = 2,
    parameter int SCAN_DIV    = 5000,
    parameter int DEBOUNCE    = 48,
    parameter int REFRESH_DIV = 5000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         cols,
    output logic [3:0]         rows,
    output logic [NDIGITS-1:0] digit_en,
    output logic [6:0]         seg,
    output logic               key_valid,
    output logic [3:0]         key_code
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int NW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [NW-1:0] SLOT_LAST = NW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB,
        ST_HELD
    } state_t;

    logic [3:0]    sync1_q;
    logic [3:0]    scols_q;
    state_t        state_q, state_d;
    logic [3:0]    rows_q, rows_d;
    logic [3:0]    cap_q, cap_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          accept;
    logic [3:0]    code;
    logic          key_valid_q;
    logic [3:0]    key_code_q;

    logic [NDIGITS-1:0][3:0] dig_q;
    logic [NDIGITS-1:0]      dv_q;
    logic [RW-1:0]           rcnt_q;
    logic [NW-1:0]           slot_q;
    logic [3:0]              cur_dig;
    logic                    cur_vld;

    function automatic logic [3:0] key_of(
        input logic [3:0] r,
        input logic [3:0] c
    );
        logic [1:0] ri;
        logic [1:0] ci;
        logic [3:0] k;
        ri = '0;
        ci = '0;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) ri = 2'(i);
            if (c[i]) ci = 2'(i);
        end
        case ({ri, ci})
            4'd0:    k = 4'h1;
            4'd1:    k = 4'h2;
            4'd2:    k = 4'h3;
            4'd3:    k = 4'hA;
            4'd4:    k = 4'h4;
            4'd5:    k = 4'h5;
            4'd6:    k = 4'h6;
            4'd7:    k = 4'hB;
            4'd8:    k = 4'h7;
            4'd9:    k = 4'h8;
            4'd10:   k = 4'h9;
            4'd11:   k = 4'hC;
            4'd12:   k = 4'hE;
            4'd13:   k = 4'h0;
            4'd14:   k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Active-high glyph {g,f,e,d,c,b,a}; inverted at the pin.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign code = key_of(rows_q, cap_q);

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        cap_d   = cap_q;
        scnt_d  = scnt_q;
        dcnt_d  = dcnt_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_SCAN: begin
                if (scols_q != 4'd0) begin
                    cap_d   = scols_q;
                    dcnt_d  = '0;
                    scnt_d  = '0;
                    state_d = ST_DEB;
                end else if (scnt_q == SCAN_LAST) begin
                    scnt_d = '0;
                    rows_d = {rows_q[2:0], rows_q[3]};
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_DEB: begin
                if (scols_q != cap_q || scols_q == 4'd0) begin
                    state_d = ST_SCAN;
                end else if (dcnt_q == DEB_LAST) begin
                    dcnt_d  = '0;
                    state_d = ST_HELD;
                    // Several columns at once are ambiguous: swallow them.
                    accept  = ((cap_q & (cap_q - 4'd1)) == 4'd0);
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (scols_q != 4'd0) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    dcnt_d  = '0;
                    state_d = ST_SCAN;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            scols_q     <= '0;
            state_q     <= ST_SCAN;
            rows_q      <= 4'b0001;
            cap_q       <= '0;
            scnt_q      <= '0;
            dcnt_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            dig_q       <= '0;
            dv_q        <= '0;
        end else begin
            sync1_q     <= cols;
            scols_q     <= sync1_q;
            state_q     <= state_d;
            rows_q      <= rows_d;
            cap_q       <= cap_d;
            scnt_q      <= scnt_d;
            dcnt_q      <= dcnt_d;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= code;
                for (int i = NDIGITS - 1; i > 0; i--) begin
                    dig_q[i] <= dig_q[i-1];
                    dv_q[i]  <= dv_q[i-1];
                end
                dig_q[0] <= code;
                dv_q[0]  <= 1'b1;
            end
        end
    end

    // Refresh runs free of the scanner; history shifts show up next slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt_q <= '0;
            slot_q <= '0;
        end else if (rcnt_q == REF_LAST) begin
            rcnt_q <= '0;
            slot_q <= (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end else begin
            rcnt_q <= rcnt_q + 1'b1;
        end
    end

    always_comb begin
        cur_dig = '0;
        cur_vld = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (slot_q == NW'(i)) begin
                cur_dig = dig_q[i];
                cur_vld = dv_q[i];
            end
        end
    end

    assign seg       = cur_vld ? ~glyph(cur_dig) : 7'h7F;
    assign digit_en  = NDIGITS'(1) << slot_q;
    assign rows      = rows_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_mux_display.sv
// Bench for keypad_mux_display: physical keypad model, key scoreboard
// and a display reference built from the accepted-key history.
module tb_keypad_mux_display;
    localparam int ND = 3;
    localparam int SD = 4;
    localparam int DB = 8;
    localparam int RD = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    cols;
    logic [3:0]    rows;
    logic [ND-1:0] digit_en;
    logic [6:0]    seg;
    logic          key_valid;
    logic [3:0]    key_code;

    logic [15:0] kdown = '0;
    int errors = 0;
    int checks = 0;
    int n = 0;
    int exp_q[$];
    int hist[ND];
    bit hv[ND];
    int mon_e, mon_s;

    int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11,
                       7, 8, 9, 12, 14, 0, 15, 13};
    int gl[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                   'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    keypad_mux_display #(
        .NDIGITS(ND), .SCAN_DIV(SD),
        .DEBOUNCE(DB), .REFRESH_DIV(RD)
    ) dut (
        .clk(clk), .reset(reset), .cols(cols), .rows(rows),
        .digit_en(digit_en), .seg(seg),
        .key_valid(key_valid), .key_code(key_code)
    );

    always #5 clk = ~clk;

    // A pressed key connects its row line to its column line.
    always_comb begin
        cols = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (rows[r] && kdown[r*4+c]) cols[c] = 1'b1;
    end

    always @(posedge clk or negedge reset)
        if (!reset) n <= 0;
        else n <= n + 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int segof(input int d);
        return ~gl[d] & 'h7F;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("kv_in_reset", key_valid, 0);
            for (int i = 0; i < ND; i++) begin
                hv[i] = 0;
                hist[i] = 0;
            end
        end else begin
            if (key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_key_valid", key_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("key_code", key_code, mon_e);
                    for (int i = ND - 1; i > 0; i--) begin
                        hist[i] = hist[i-1];
                        hv[i] = hv[i-1];
                    end
                    hist[0] = mon_e;
                    hv[0] = 1;
                end
            end
            mon_s = (n / RD) % ND;
            chk("digit_en", digit_en, 1 << mon_s);
            chk("seg", seg, hv[mon_s] ? segof(hist[mon_s]) : 'h7F);
        end
    end

    task automatic chk_reset_vals();
        chk("rst_rows", rows, 4'b0001);
        chk("rst_digit_en", digit_en, 1);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_code", key_code, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 reset = 1'b0;
        #1 chk_reset_vals();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_accept();
        int k = 0;
        while (exp_q.size() != 0 && k < 150) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_scan_resume(input string name);
        logic [3:0] r0;
        int k = 0;
        r0 = rows;
        while (rows === r0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, (rows !== r0), 1);
    endtask

    task automatic press(input int code, input bit bounce,
                         input int hold);
        int idx = 0;
        for (int i = 0; i < 16; i++)
            if (keymap[i] == code) idx = i;
        if (bounce) begin
            for (int t = 0; t < 10; t++) begin
                kdown[idx] = ~kdown[idx];
                repeat (3) @(negedge clk);
            end
        end
        kdown[idx] = 1'b1;
        exp_q.push_back(code);
        wait_accept();
        repeat (hold) @(negedge clk);
        kdown[idx] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_slot(input int s);
        int k = 0;
        while (digit_en !== ND'(1 << s) && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b1;

        // Idle rotation, first step SD cycles after reset release.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("idle_rows", rows, 1 << ((n / SD) % 4));
        end

        // Clean press of 8 (row2, col1), long hold, release.
        press(8, 0, 100);
        kdown[9] = 1'b1;
        exp_q.push_back(8);
        wait_accept();
        repeat (100) @(negedge clk);
        chk("held_row_frozen", rows, 4'b0100);
        kdown[9] = 1'b0;
        wait_scan_resume("scan_resume_after_8");
        repeat (20) @(negedge clk);

        press(5, 1, 10);

        // Two columns on row0: swallowed, row stays frozen.
        kdown[0] = 1'b1;
        kdown[1] = 1'b1;
        repeat (30) @(negedge clk);
        chk("multi_row", rows, 4'b0001);
        repeat (20) @(negedge clk);
        chk("multi_frozen", rows, 4'b0001);
        kdown[0] = 1'b0;
        kdown[1] = 1'b0;
        wait_scan_resume("scan_resume_after_multi");

        // Reset four cycles into debounce of key 1.
        do_reset();
        kdown[0] = 1'b1;
        repeat (7) @(negedge clk);
        #3 reset = 1'b0;
        #1 chk_reset_vals();
        kdown[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        press(1, 0, 5);
        press(2, 0, 5);
        wait_slot(2);
        chk("blank_slot2", seg, 7'h7F);
        press(3, 0, 5);
        press(4, 0, 5);
        wait_slot(0);
        chk("hist_slot0", seg, segof(4));
        wait_slot(1);
        chk("hist_slot1", seg, segof(3));
        wait_slot(2);
        chk("hist_slot2", seg, segof(2));

        for (int i = 0; i < 12; i++)
            press($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 30));

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
